// File: rtl/magnitude_search_ctrl.sv
// Binary-search controller: drives a probe into an external comparator and
// narrows [low, high] from its less/equal/greater flags until a hit or an empty range.
module magnitude_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic [3:0]       steps
);

    typedef enum logic [1:0] {IDLE, PROBE, DONE, ERR} state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] low_reg,    low_next;
    logic [WIDTH-1:0] high_reg,   high_next;
    logic [WIDTH-1:0] probe_reg,  probe_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             found_reg,  found_next;
    logic [3:0]       steps_reg,  steps_next;
    logic [WIDTH:0]   mid_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            low_reg    <= '0;
            high_reg   <= '0;
            probe_reg  <= '0;
            result_reg <= '0;
            found_reg  <= 1'b0;
            steps_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            low_reg    <= low_next;
            high_reg   <= high_next;
            probe_reg  <= probe_next;
            result_reg <= result_next;
            found_reg  <= found_next;
            steps_reg  <= steps_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        low_next    = low_reg;
        high_next   = high_reg;
        probe_next  = probe_reg;
        result_next = result_reg;
        found_next  = found_reg;
        steps_next  = steps_reg;
        mid_sum     = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = PROBE;
                    low_next    = '0;
                    high_next   = MAX_VAL;
                    probe_next  = MAX_VAL >> 1;
                    steps_next  = '0;
                    found_next  = 1'b0;
                    result_next = '0;
                end
            end
            PROBE: begin
                steps_next = steps_reg + 4'd1;
                case ({less, equal, greater})
                    3'b010: begin
                        result_next = probe_reg;
                        found_next  = 1'b1;
                        state_next  = DONE;
                    end
                    3'b100: begin
                        // Guard probe==0 so high never wraps below zero
                        if (probe_reg == '0) begin
                            state_next = DONE;
                        end else begin
                            high_next = probe_reg - ONE;
                            if (low_reg > high_next) begin
                                state_next = DONE;
                            end else begin
                                mid_sum    = {1'b0, low_reg} + {1'b0, high_next};
                                probe_next = WIDTH'(mid_sum >> 1);
                            end
                        end
                    end
                    3'b001: begin
                        if (probe_reg == MAX_VAL) begin
                            state_next = DONE;
                        end else begin
                            low_next = probe_reg + ONE;
                            if (low_next > high_reg) begin
                                state_next = DONE;
                            end else begin
                                mid_sum    = {1'b0, low_next} + {1'b0, high_reg};
                                probe_next = WIDTH'(mid_sum >> 1);
                            end
                        end
                    end
                    default: state_next = ERR;
                endcase
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign probe  = probe_reg;
    assign result = result_reg;
    assign found  = found_reg;
    assign steps  = steps_reg;
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign error  = (state_reg == ERR);

endmodule
